// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences MEM-stage load/store requests onto a single-outstanding data bus
// with a req/ack handshake. It stalls the pipeline while a transfer is in
// flight, builds byte enables and lane-replicated store data, and formats load
// data with sign or zero extension for the write-back path.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   req_i            MEM stage holds a valid load/store
//   we_i             1 = store, 0 = load
//   size_i           00 byte, 01 half, 10/11 word
//   unsigned_i       zero-extend (1) or sign-extend (0) load data
//   addr_i, wdata_i  byte address, store data (low bits)
//   stall_o          hold the pipeline
//   done_o           one-cycle completion pulse
//   rdata_o          formatted load data, valid with done_o
//   err_o            bus timeout, pulses with done_o
//   misalign_o       misaligned-access trap, pulses with done_o
//   bus_*            single-outstanding data bus
//
// Build option
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word requests complete
//                         immediately with misalign_o instead of going to the
//                         bus. When undefined, the low address bits below the
//                         access size are ignored and misalign_o stays 0.
//
// state | meaning
// IDLE  | no access; sample req_i
// BUS   | bus_req_o held, waiting for bus_ack_i or timeout
// RESP  | done_o pulse, pipeline released
module mem_access_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        misalign_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter holds the number of BUS cycles already spent without ack, so the
   // abort fires in the cycle where one more miss would reach MAX_WAIT.
   localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;

   logic        bus_req_d, bus_we_d, done_d, err_d, mis_q, mis_d;
   logic [31:0] bus_addr_d, bus_wdata_d, rdata_d;
   logic [3:0]  bus_be_d;

   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   calc_be = 4'b0001 << off;
         2'b01:   calc_be = 4'b0011 << {off[1], 1'b0};
         default: calc_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   calc_wdata = {4{wd[7:0]}};
         2'b01:   calc_wdata = {2{wd[15:0]}};
         default: calc_wdata = wd;
      endcase
   endfunction

   function automatic logic [31:0] fmt_rdata(input logic [1:0] size, input logic [1:0] off,
                                             input logic uns, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{off, 3'b000} +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   fmt_rdata = {{24{~uns & b[7]}}, b};
         2'b01:   fmt_rdata = {{16{~uns & h[15]}}, h};
         default: fmt_rdata = rd;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = off[0];
         default: is_misaligned = (off != 2'b00);
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      bus_req_d   = bus_req_o;
      bus_we_d    = bus_we_o;
      bus_addr_d  = bus_addr_o;
      bus_be_d    = bus_be_o;
      bus_wdata_d = bus_wdata_o;
      rdata_d     = rdata_o;
      done_d      = 1'b0;
      err_d       = 1'b0;
      mis_d       = 1'b0;
      stall_o     = 1'b0;

      case (state_q)
         IDLE: begin
            stall_o = req_i;
            if (req_i) begin
               if (TRAP_EN && is_misaligned(size_i, addr_i[1:0])) begin
                  done_d  = 1'b1;
                  mis_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end else begin
                  size_d      = size_i;
                  uns_d       = unsigned_i;
                  off_d       = addr_i[1:0];
                  bus_req_d   = 1'b1;
                  bus_we_d    = we_i;
                  bus_addr_d  = {addr_i[31:2], 2'b00};
                  bus_be_d    = calc_be(size_i, addr_i[1:0]);
                  bus_wdata_d = calc_wdata(size_i, wdata_i);
                  cnt_d       = '0;
                  state_d     = BUS;
               end
            end
         end
         BUS: begin
            stall_o = 1'b1;
            if (bus_ack_i) begin
               bus_req_d = 1'b0;
               rdata_d   = bus_we_o ? 32'h0 : fmt_rdata(size_q, off_q, uns_q, bus_rdata_i);
               done_d    = 1'b1;
               state_d   = RESP;
            end else if (cnt_q == LAST_WAIT) begin
               bus_req_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
               done_d    = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) stall_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
         rdata_o     <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         bus_req_o   <= bus_req_d;
         bus_we_o    <= bus_we_d;
         bus_addr_o  <= bus_addr_d;
         bus_be_o    <= bus_be_d;
         bus_wdata_o <= bus_wdata_d;
         rdata_o     <= rdata_d;
         done_o      <= done_d;
         err_o       <= err_d;
         mis_q       <= mis_d;
      end
   end

   // Without the trap build mis_d is never set, so this stays 0 after reset.
   assign misalign_o = mis_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences load/store requests from the MEM pipeline stage onto a single-outstanding data bus with a req/ack handshake.
- Stalls the pipeline while a transfer is in flight.
- Generates byte enables and write-data lane replication, and formats read data with sign/zero extension.
- Sits between the mem stage and data memory; the formatted load result and done pulse feed the MEM/WB write-back path.

Parameters:
- MAX_WAIT, 255: bus cycles to wait for bus_ack_i before aborting with err_o. Range 1..65535; counter width is 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  1  MEM stage holds a valid load/store this cycle.
- we_i  input  1  1 = store, 0 = load.
- size_i  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- unsigned_i  input  1  zero-extend load result when 1; sign-extend when 0.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, taken from the low bits.
- stall_o  output  1  hold the pipeline.
- done_o  output  1  one-cycle pulse: access complete.
- rdata_o  output  32  formatted load data; valid while done_o=1.
- err_o  output  1  one-cycle pulse with done_o on bus timeout.
- misalign_o  output  1  one-cycle pulse with done_o on misaligned access (optional feature).
- bus_req_o  output  1  bus request.
- bus_we_o  output  1  bus write.
- bus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}.
- bus_be_o  output  4  byte enables.
- bus_wdata_o  output  32  lane-replicated store data.
- bus_rdata_i  input  32  bus read data; valid when bus_ack_i=1.
- bus_ack_i  input  1  bus completion.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- States: IDLE, BUS, RESP.
- Reset (synchronous, any state):
  - State goes to IDLE; wait counter cleared.
  - All registered outputs go to 0: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, done_o, rdata_o, err_o, misalign_o.
  - stall_o is 0 while rst=1.
  - Reset mid-transfer abandons the access; bus_req_o is low from the next edge; no done_o is produced.
- IDLE:
  - stall_o = req_i (combinational).
  - On req_i=1: latch we/size/unsigned/addr/wdata; drive bus_req_o=1 with addr/be/wdata from the next edge; go to BUS.
  - bus_ack_i is ignored.
- BUS:
  - stall_o=1.
  - bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are held stable until ack.
  - Wait counter increments each cycle without ack.
  - On bus_ack_i=1: bus_req_o drops at that edge; rdata_o is registered from formatted bus_rdata_i (0 for a store); go to RESP.
  - If the counter reaches MAX_WAIT with no ack: abort, bus_req_o drops, rdata_o=0, err_o=1, go to RESP.
  - An ack in the same cycle the counter hits MAX_WAIT counts as success: no error.
- RESP:
  - done_o=1 for exactly one cycle; stall_o=0 so the pipeline advances.
  - req_i is ignored (it belongs to the retiring instruction); return to IDLE.
  - The next request is sampled in the following IDLE cycle.
- Latency: req_i in cycle 0 -> bus_req_o high in cycle 1 -> ack in cycle 1 -> done_o in cycle 2. Each extra wait cycle adds one.
- Byte enables, with o = addr[1:0]:
  - byte: 4'b0001 << o.
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Store data: byte replicated into all 4 lanes; half replicated into both halves; word unchanged.
- Load data: select the lane by o (byte) or addr[1] (half), then zero-extend (unsigned_i=1) or sign-extend from bit 7/15.
- bus_ack_i outside BUS has no effect.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - In IDLE, a misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) performs no bus access.
  - Goes directly to RESP: done_o=1, misalign_o=1, rdata_o=0; stall_o=1 only in the request cycle.
- Not defined:
  - misalign_o is tied to 0.
  - Low address bits below the access size are ignored: half uses addr[1] only; word uses an aligned address.

Test Plan:
- Word load, addr=0x100, ack in the first BUS cycle, rdata=0xDEADBEEF:
  - bus_be=1111 and bus_addr=0x100 in cycle 1.
  - done_o=1 in cycle 2 with rdata_o=0xDEADBEEF.
  - stall_o=1 in cycles 0-1, 0 in cycle 2.
- Byte load, addr=0x103, signed, bus_rdata=0x80000000, ack after 3 wait cycles:
  - bus_be=1000; rdata_o=0xFFFFFF80.
  - Repeat unsigned -> rdata_o=0x00000080.
  - done_o 5 cycles after req.
- Half store, addr=0x22, wdata=0x1234ABCD:
  - bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x20.
  - Address/data stable through 2 wait cycles; done_o with rdata_o=0.
- Timeout, MAX_WAIT=4, no ack:
  - bus_req_o high for 4 cycles, then drops.
  - err_o=1 and done_o=1 together, rdata_o=0, stall_o released.
- Reset asserted in the 2nd BUS cycle:
  - bus_req_o=0 and all outputs 0 after that edge; no done_o.
  - Next request after reset completes normally.
- MEM_MISALIGN_TRAP_EN, word load at 0x102:
  - bus_req_o never rises; done_o=1 and misalign_o=1 in cycle 1.
  - Without the macro: access to 0x100 with be=1111.
